bitwise_logic_unit: RTL and testbench

- Parametrised, registered successor to the team's fixed-width bitwise AND block.
- Computes one of eight bitwise functions on WIDTH-bit operands behind valid/ready handshakes on both input and output.
- Accumulate mode folds a multi-beat packet into a single result, combining the per-beat results with a selectable reduction.
- Sits between operand sources and downstream datapath stages in the logic-design lab pipeline.

---
 rtl/bitwise_logic_unit.sv | 181 ++++++++++++++++++
 tb/tb_bitwise_logic_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : bitwise_logic_unit
// Description : Registered bitwise function unit with valid/ready handshakes
//               and a multi-beat accumulate mode that folds per-beat results.
// Revision    : 1.0 - initial release
// ============================================================================
module bitwise_logic_unit #(
    parameter int WIDTH     = 20,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic [1:0]       in_acc_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_ovf
);

    localparam logic [0:0]       c_IDLE      = 1'b0;
    localparam logic [0:0]       c_ACCUM     = 1'b1;
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_MAX_BEATS = CNT_W'(MAX_BEATS);

    function automatic logic [WIDTH-1:0] beat_fn(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a ^ b;
            3'b011:  r = ~(a & b);
            3'b100:  r = ~(a | b);
            3'b101:  r = ~(a ^ b);
            3'b110:  r = a & ~b;
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] reduce_fn(input logic [1:0] rop,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (rop)
            2'b00:   r = x & y;
            2'b10:   r = x ^ y;
            default: r = x | y;
        endcase
        return r;
    endfunction

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [1:0]       r_acc_op;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_y;
    logic             r_out_zero;
    logic             r_out_ones;
    logic [CNT_W-1:0] r_out_beats;
    logic             r_out_ovf;

    logic             w_in_ready;
    logic             w_accept;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_f;
    logic [WIDTH-1:0] w_fold;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_op_nxt;
    logic [1:0]       w_acc_op_nxt;
    logic             w_emit;
    logic [WIDTH-1:0] w_y_nxt;
    logic [CNT_W-1:0] w_beats_nxt;
    logic             w_ovf_nxt;

    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;
    // Mid-packet beats use the function latched from the opening beat.
    assign w_op       = (r_state == c_ACCUM) ? r_op : in_op;
    assign w_f        = beat_fn(w_op, in_a, in_b);
    assign w_fold     = reduce_fn(r_acc_op, r_acc, w_f);
    assign w_cnt_inc  = r_cnt + c_ONE;

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_op_nxt     = r_op;
        w_acc_op_nxt = r_acc_op;
        w_emit       = 1'b0;
        w_y_nxt      = w_f;
        w_beats_nxt  = c_ONE;
        w_ovf_nxt    = 1'b0;
        if (w_accept) begin
            if (r_state == c_IDLE) begin
                if (in_acc && !in_last) begin
                    w_acc_nxt    = w_f;
                    w_op_nxt     = in_op;
                    w_acc_op_nxt = in_acc_op;
                    w_cnt_nxt    = c_ONE;
                    w_state_nxt  = c_ACCUM;
                end else begin
                    w_emit = 1'b1;
                end
            end else begin
                if (in_last || (w_cnt_inc == c_MAX_BEATS)) begin
                    w_emit      = 1'b1;
                    w_y_nxt     = w_fold;
                    w_beats_nxt = w_cnt_inc;
                    w_ovf_nxt   = !in_last;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_IDLE;
                end else begin
                    w_acc_nxt = w_fold;
                    w_cnt_nxt = w_cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_op        <= '0;
            r_acc_op    <= '0;
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_zero  <= 1'b0;
            r_out_ones  <= 1'b0;
            r_out_beats <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_op     <= w_op_nxt;
            r_acc_op <= w_acc_op_nxt;
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_y     <= w_y_nxt;
                r_out_zero  <= (w_y_nxt == '0);
                r_out_ones  <= &w_y_nxt;
                r_out_beats <= w_beats_nxt;
                r_out_ovf   <= w_ovf_nxt;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign out_zero  = r_out_zero;
    assign out_ones  = r_out_ones;
    assign out_beats = r_out_beats;
    assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitwise_logic_unit
// Description : Directed self-checking bench for bitwise_logic_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitwise_logic_unit;

    localparam int WIDTH     = 20;
    localparam int MAX_BEATS = 4;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [2:0]       in_op = '0;
    logic             in_acc = 1'b0;
    logic [1:0]       in_acc_op = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic             out_ones;
    logic [CNT_W-1:0] out_beats;
    logic             out_ovf;

    int errors = 0;
    int checks = 0;

    // observed bundle: {valid, y, zero, ones, beats, ovf}
    logic [WIDTH+CNT_W+3:0] obs;
    assign obs = {out_valid, out_y, out_zero, out_ones, out_beats, out_ovf};

    bitwise_logic_unit #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .in_acc(in_acc), .in_acc_op(in_acc_op), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_zero(out_zero), .out_ones(out_ones),
        .out_beats(out_beats), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] op, input logic acc,
                        input logic [1:0] acc_op, input logic last);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_acc    = acc;
        in_acc_op = acc_op;
        in_last   = last;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_acc   = 1'b0;
        in_last  = 1'b0;
    endtask

    function automatic logic [WIDTH+CNT_W+3:0] exp_of(input logic v,
            input logic [WIDTH-1:0] y, input logic [CNT_W-1:0] bt, input logic ovf);
        return {v, y, (y == '0), (&y), bt, ovf};
    endfunction

    task automatic test_reset();
        #3;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, {(WIDTH+CNT_W+4){1'b0}});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_and();
        beat(20'hF0F0F, 20'h0FF0F, 3'b000, 1'b0, 2'b00, 1'b0);
        step();
        idle();
        checks++;
        if (obs !== exp_of(1'b1, 20'h00F0F, 3'd1, 1'b0)) begin
            errors++;
            $display("FAIL single_and: got %h expected %h", obs, exp_of(1'b1, 20'h00F0F, 3'd1, 1'b0));
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_and_drain: got valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        beat(20'hF0F0F, 20'h0FF0F, 3'b010, 1'b0, 2'b00, 1'b0);
        step();
        beat(20'hFFFFF, 20'hFFFFF, 3'b011, 1'b0, 2'b00, 1'b0);
        checks++;
        if (obs !== exp_of(1'b1, 20'hFF000, 3'd1, 1'b0)) begin
            errors++;
            $display("FAIL b2b_xor: got %h expected %h", obs, exp_of(1'b1, 20'hFF000, 3'd1, 1'b0));
        end
        step();
        beat(20'h00000, 20'h00000, 3'b100, 1'b0, 2'b00, 1'b0);
        checks++;
        if (obs !== exp_of(1'b1, 20'h00000, 3'd1, 1'b0)) begin
            errors++;
            $display("FAIL b2b_nand: got %h expected %h", obs, exp_of(1'b1, 20'h00000, 3'd1, 1'b0));
        end
        step();
        idle();
        checks++;
        if (obs !== exp_of(1'b1, 20'hFFFFF, 3'd1, 1'b0)) begin
            errors++;
            $display("FAIL b2b_nor_ones: got %h expected %h", obs, exp_of(1'b1, 20'hFFFFF, 3'd1, 1'b0));
        end
        step();
    endtask

    task automatic test_accum();
        beat(20'h00001, 20'hFFFFF, 3'b000, 1'b1, 2'b01, 1'b0);
        step();
        beat(20'h00010, 20'hFFFFF, 3'b101, 1'b0, 2'b10, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL accum_early1: got valid %b expected 0", out_valid);
        end
        step();
        // op/acc_op here differ from the opening beat and must be ignored
        beat(20'h10000, 20'h10000, 3'b110, 1'b0, 2'b00, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL accum_early2: got valid %b expected 0", out_valid);
        end
        step();
        idle();
        checks++;
        if (obs !== exp_of(1'b1, 20'h10011, 3'd3, 1'b0)) begin
            errors++;
            $display("FAIL accum_result: got %h expected %h", obs, exp_of(1'b1, 20'h10011, 3'd3, 1'b0));
        end
        step();
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] av [4];
        av[0] = 20'h1; av[1] = 20'h2; av[2] = 20'h4; av[3] = 20'h8;
        for (int i = 0; i < 4; i++) begin
            beat(av[i], 20'h0, 3'b111, 1'b1, 2'b10, 1'b0);
            step();
            if (i < 3) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_early beat %0d: got valid %b expected 0", i, out_valid);
                end
            end
        end
        beat(20'h00003, 20'h00003, 3'b000, 1'b0, 2'b00, 1'b0);
        checks++;
        if (obs !== exp_of(1'b1, 20'h0000F, 3'd4, 1'b1)) begin
            errors++;
            $display("FAIL ovf_result: got %h expected %h", obs, exp_of(1'b1, 20'h0000F, 3'd4, 1'b1));
        end
        step();
        idle();
        checks++;
        if (obs !== exp_of(1'b1, 20'h00003, 3'd1, 1'b0)) begin
            errors++;
            $display("FAIL ovf_next_single: got %h expected %h", obs, exp_of(1'b1, 20'h00003, 3'd1, 1'b0));
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        beat(20'h12345, 20'h00F00, 3'b001, 1'b0, 2'b00, 1'b0);
        step();
        beat(20'hAAAAA, 20'h55555, 3'b010, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs !== exp_of(1'b1, 20'h12F45, 3'd1, 1'b0)) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got %h expected %h", i, obs, exp_of(1'b1, 20'h12F45, 3'd1, 1'b0));
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready cycle %0d: got %b expected 0", i, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b expected 1", in_ready);
        end
        step();
        idle();
        checks++;
        if (obs !== exp_of(1'b1, 20'hFFFFF, 3'd1, 1'b0)) begin
            errors++;
            $display("FAIL bp_second: got %h expected %h", obs, exp_of(1'b1, 20'hFFFFF, 3'd1, 1'b0));
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_dup: got valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_packet();
        beat(20'hFFFFF, 20'h000F0, 3'b000, 1'b1, 2'b01, 1'b0);
        step();
        beat(20'hFFFFF, 20'h00F00, 3'b000, 1'b1, 2'b01, 1'b0);
        step();
        idle();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got valid %b ready %b expected valid 0 ready 1", out_valid, in_ready);
        end
        #2 rst_n = 1'b1;
        beat(20'hFFFFF, 20'h0000F, 3'b000, 1'b0, 2'b00, 1'b0);
        step();
        idle();
        checks++;
        if (obs !== exp_of(1'b1, 20'h0000F, 3'd1, 1'b0)) begin
            errors++;
            $display("FAIL post_reset_and: got %h expected %h", obs, exp_of(1'b1, 20'h0000F, 3'd1, 1'b0));
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single_and();
        test_back_to_back();
        test_accum();
        test_overflow();
        test_backpressure();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
